// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, framebuffer geometry, swap FSM type
//
// Contents:
//   H_* / V_*        640x480@60 timing in pixels / lines, with totals
//   FB_W / FB_H      framebuffer geometry (2x upscaled onto the visible area)
//   swap_state_t     states of the buffer swap FSM
//   expand2          2-bit colour field to 8-bit channel value
package vga_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int FB_W = 320;
  localparam int FB_H = 240;

  typedef enum logic {
    DISPLAY = 1'b0,
    SWAP    = 1'b1
  } swap_state_t;

  // Replicating the field spreads the 2-bit range evenly over 0x00..0xFF.
  function automatic logic [7:0] expand2(input logic [1:0] c);
    return {c, c, c, c};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel tick, hc/vc counters and raw sync/blank generation
//
// Ports:
//   clk, reset_n       system clock, asynchronous active-low reset
//   pix_tick           high on every other clk; counters advance on these clks
//   vga_clk            pix_tick delayed one clk (pixel clock for the DAC)
//   fb_x, fb_y         counters halved (hc[9:1], vc[8:1]), ungated
//   visible            hc/vc inside the active picture
//   hs_raw, vs_raw     active-low syncs decoded from the current counters
//   frame_tick         pixel tick at hc=0, vc=0
//   vblank_tick        pixel tick at hc=0, vc=V_VIS (first blanked line)
module vga_timing #(
  parameter int H_VIS  = vga_pkg::H_VIS,
  parameter int H_FP   = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP   = vga_pkg::H_BP,
  parameter int V_VIS  = vga_pkg::V_VIS,
  parameter int V_FP   = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP   = vga_pkg::V_BP
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       pix_tick,
  output logic       vga_clk,
  output logic [8:0] fb_x,
  output logic [7:0] fb_y,
  output logic       visible,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       frame_tick,
  output logic       vblank_tick
);

  localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_L = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L = 10'(V_VIS);
  localparam logic [9:0] HS_ON   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_OFF  = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_ON   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_OFF  = 10'(V_VIS + V_FP + V_SYNC);

  logic [9:0] hc;
  logic [9:0] vc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_tick <= 1'b0;
      vga_clk  <= 1'b0;
      hc       <= '0;
      vc       <= '0;
    end else begin
      pix_tick <= ~pix_tick;
      vga_clk  <= pix_tick;
      if (pix_tick) begin
        if (hc == H_LAST) begin
          hc <= '0;
          vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
        end else begin
          hc <= hc + 10'd1;
        end
      end
    end
  end

  assign fb_x        = hc[9:1];
  assign fb_y        = vc[8:1];
  assign visible     = (hc < H_VIS_L) && (vc < V_VIS_L);
  assign hs_raw      = !((hc >= HS_ON) && (hc < HS_OFF));
  assign vs_raw      = !((vc >= VS_ON) && (vc < VS_OFF));
  assign frame_tick  = pix_tick && (hc == '0) && (vc == '0);
  assign vblank_tick = pix_tick && (hc == '0) && (vc == V_VIS_L);

endmodule

// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - 2x-upscaling framebuffer scanout with VGA timing and buffer swap
//
// Ports:
//   clk, reset_n              50 MHz clock, asynchronous active-low reset
//   read_row, read_col        framebuffer address (0 outside the visible area)
//   read_data                 RRGGBB pixel, valid one clk after the address
//   buffer_sel                displayed buffer select (0: buffer 1 shown)
//   swap_req, swap_ack        draw-engine swap handshake (ack is a 1-clk pulse)
//   vga_clk, vga_hs, vga_vs   pixel clock and active-low syncs
//   vga_blank_n               high while visible pixels are driven
//   vga_r, vga_g, vga_b       8-bit colour, zero during blanking
//   frame_start               1-clk pulse at the pixel tick of hc=0, vc=0
module fb_scanout #(
  parameter int H_VIS  = vga_pkg::H_VIS,
  parameter int H_FP   = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP   = vga_pkg::H_BP,
  parameter int V_VIS  = vga_pkg::V_VIS,
  parameter int V_FP   = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP   = vga_pkg::V_BP
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [8:0] read_row,
  output logic [7:0] read_col,
  input  logic [5:0] read_data,
  output logic       buffer_sel,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       vga_clk,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       frame_start
);
  import vga_pkg::*;

  logic       pix_tick;
  logic [8:0] fb_x;
  logic [7:0] fb_y;
  logic       visible, hs_raw, vs_raw, vblank_tick;
  logic       hs_s1, vs_s1, blank_s1;
  logic [5:0] pix_hold;

  swap_state_t state, state_nx;

  vga_timing #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_tick   (pix_tick),
    .vga_clk    (vga_clk),
    .fb_x       (fb_x),
    .fb_y       (fb_y),
    .visible    (visible),
    .hs_raw     (hs_raw),
    .vs_raw     (vs_raw),
    .frame_tick (frame_start),
    .vblank_tick(vblank_tick)
  );

  assign read_row = visible ? fb_x : '0;
  assign read_col = visible ? fb_y : '0;

  // The RAM latches the address at the pixel tick and answers on the
  // following (non-tick) clk; by the next tick it is already answering the
  // next address. pix_hold captures the answer on the non-tick clk so the
  // colour registered at the next tick belongs to the same pixel as stage 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_hold    <= '0;
      hs_s1       <= 1'b1;
      vs_s1       <= 1'b1;
      blank_s1    <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else if (!pix_tick) begin
      pix_hold <= read_data;
    end else begin
      hs_s1       <= hs_raw;
      vs_s1       <= vs_raw;
      blank_s1    <= visible;
      vga_hs      <= hs_s1;
      vga_vs      <= vs_s1;
      vga_blank_n <= blank_s1;
      vga_r       <= blank_s1 ? expand2(pix_hold[5:4]) : 8'h00;
      vga_g       <= blank_s1 ? expand2(pix_hold[3:2]) : 8'h00;
      vga_b       <= blank_s1 ? expand2(pix_hold[1:0]) : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= DISPLAY;
      buffer_sel <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == SWAP) begin
        buffer_sel <= ~buffer_sel;
      end
    end
  end

  // Swaps are only taken at the first blanked line, so the displayed buffer
  // is constant across every visible line of a frame.
  always_comb begin
    state_nx = state;
    swap_ack = 1'b0;
    case (state)
      DISPLAY: if (vblank_tick && swap_req) state_nx = SWAP;
      SWAP: begin
        swap_ack = 1'b1;
        state_nx = DISPLAY;
      end
      default: state_nx = DISPLAY;
    endcase
  end

endmodule

// File: tb/tb_fb_scanout.sv
// tb/tb_fb_scanout.sv - randomized self-checking bench for fb_scanout (scaled timing)
module tb_fb_scanout;

  localparam int HV = 32, HFP = 4, HSY = 8, HBP = 4;
  localparam int HT = HV + HFP + HSY + HBP;
  localparam int VV = 24, VFP = 2, VSY = 2, VBP = 4;
  localparam int VT = VV + VFP + VSY + VBP;
  localparam int FRAME = 2 * HT * VT;

  logic       clk, reset_n;
  logic [8:0] read_row;
  logic [7:0] read_col;
  logic [5:0] read_data;
  logic       buffer_sel, swap_req, swap_ack;
  logic       vga_clk, vga_hs, vga_vs, vga_blank_n, frame_start;
  logic [7:0] vga_r, vga_g, vga_b;

  logic [5:0] fb [0:319][0:239];

  int n_checks = 0;
  int n_fail   = 0;

  int   k, fb_mode, toggles;
  int   hs_fall, vs_fall, fs_last;
  logic sel_exp, ack_exp, prev_hs, prev_vs, prev_sel;
  bit   seen_ack;

  fb_scanout #(
    .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .read_row   (read_row),
    .read_col   (read_col),
    .read_data  (read_data),
    .buffer_sel (buffer_sel),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .vga_clk    (vga_clk),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_blank_n(vga_blank_n),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) read_data <= fb[read_row][read_col];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (k=%0d t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  function automatic logic [7:0] x4(input int c);
    return 8'(c * 85);
  endfunction

  function automatic int m_hc();
    return (k / 2) % HT;
  endfunction

  function automatic int m_vc();
    return ((k / 2) / HT) % VT;
  endfunction

  task automatic fill(input int mode);
    fb_mode = mode;
    for (int x = 0; x < 320; x++)
      for (int y = 0; y < 240; y++)
        fb[x][y] = (mode == 0) ? 6'((x + y) & 63) : (mode == 1) ? 6'h3F : 6'($urandom);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_addr"}, 32'({read_row, read_col}), 32'd0);
    check_eq({tag, "_sync"}, 32'({vga_clk, vga_hs, vga_vs, vga_blank_n, frame_start}), 32'b01100);
    check_eq({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
    check_eq({tag, "_swap"}, 32'({buffer_sel, swap_ack}), 32'd0);
  endtask

  task automatic release_reset();
    reset_n  = 1'b1;
    k        = 0;
    sel_exp  = 1'b0;
    ack_exp  = 1'b0;
    hs_fall  = -1;
    vs_fall  = -1;
    fs_last  = -1;
    prev_hs  = 1'b1;
    prev_vs  = 1'b1;
    prev_sel = 1'b0;
    toggles  = 0;
    seen_ack = 1'b0;
  endtask

  // One clk: compare against the reference for cycle k, then advance.
  task automatic step();
    int p, hc, vc, c, chc, cvc;
    bit tick, vis, hs_e, vs_e, bl_e, vclk_e, fs_e;
    logic [5:0]  d;
    logic [23:0] rgb_e;
    p    = k / 2;
    tick = (k % 2) == 1;
    hc   = p % HT;
    vc   = (p / HT) % VT;
    vis  = (hc < HV) && (vc < VV);
    check_eq("addr", 32'({read_row, read_col}), vis ? 32'((hc / 2) * 256 + vc / 2) : 32'd0);
    chc = 0;
    cvc = 0;
    if (p < 2) begin
      hs_e = 1; vs_e = 1; bl_e = 0; rgb_e = '0;
    end else begin
      c    = p - 2;
      chc  = c % HT;
      cvc  = (c / HT) % VT;
      hs_e = !(chc >= HV + HFP && chc < HV + HFP + HSY);
      vs_e = !(cvc >= VV + VFP && cvc < VV + VFP + VSY);
      bl_e = (chc < HV) && (cvc < VV);
      d    = fb[chc / 2][cvc / 2];
      rgb_e = bl_e ? {x4(int'(d[5:4])), x4(int'(d[3:2])), x4(int'(d[1:0]))} : 24'h0;
    end
    vclk_e = (k >= 1) && (((k - 1) % 2) == 1);
    fs_e   = tick && hc == 0 && vc == 0;
    check_eq("sync", 32'({vga_clk, vga_hs, vga_vs, vga_blank_n, frame_start}),
             32'({vclk_e, hs_e, vs_e, bl_e, fs_e}));
    check_eq("rgb", 32'({vga_r, vga_g, vga_b}), 32'(rgb_e));
    check_eq("swap", 32'({buffer_sel, swap_ack}), 32'({sel_exp, ack_exp}));

    if (tick && hc == 10 && vc == 7) begin
      check_eq("probe_row", 32'(read_row), 32'd5);
      check_eq("probe_col", 32'(read_col), 32'd3);
    end
    if (p >= 2 && !tick && chc == 10 && cvc == 7 && fb_mode == 0)
      check_eq("probe_rgb", 32'({vga_r, vga_g, vga_b}), 32'h00AA00);
    if (k == 1) check_eq("fs_first", 32'(frame_start), 32'd1);

    if (prev_hs && !vga_hs) begin
      if (hs_fall >= 0) check_eq("hs_period", 32'(k - hs_fall), 32'(2 * HT));
      hs_fall = k;
    end
    if (!prev_hs && vga_hs && hs_fall >= 0) check_eq("hs_low", 32'(k - hs_fall), 32'(2 * HSY));
    if (prev_vs && !vga_vs) begin
      if (vs_fall >= 0) check_eq("vs_period", 32'(k - vs_fall), 32'(FRAME));
      vs_fall = k;
    end
    if (!prev_vs && vga_vs && vs_fall >= 0) check_eq("vs_low", 32'(k - vs_fall), 32'(2 * HT * VSY));
    if (frame_start) begin
      if (fs_last >= 0) check_eq("fs_period", 32'(k - fs_last), 32'(FRAME));
      fs_last = k;
    end
    if (swap_ack) seen_ack = 1'b1;
    if (buffer_sel !== prev_sel) begin
      toggles++;
      check_eq("swap_line", 32'(vc), 32'(VV));
    end
    prev_hs  = vga_hs;
    prev_vs  = vga_vs;
    prev_sel = buffer_sel;

    // A request seen at the first blanked line's tick is acked on the next
    // clk and the select flips the clk after that.
    if (ack_exp) sel_exp = ~sel_exp;
    ack_exp = tick && hc == 0 && vc == VV && swap_req;

    @(negedge clk);
    k++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int h, input int v, input int max);
    int n = 0;
    while (!(m_hc() == h && m_vc() == v)) begin
      if (n >= max) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout_pos: hc/vc %0d/%0d not reached in %0d clk", h, v, max);
        return;
      end
      step();
      n++;
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    swap_req = 1'b0;
    k        = 0;
    fill(0);
    repeat (3) @(negedge clk);
    check_reset("por");
    release_reset();

    // two frames of plain scanout, no swap requested
    run(2 * FRAME + 40);
    check_eq("p1_toggles", 32'(toggles), 32'd0);

    // request mid-frame, drop right after the ack, no swap in the next frame
    run_until(0, 10, FRAME);
    swap_req = 1'b1;
    begin
      int n = 0;
      while (!seen_ack && n < FRAME) begin
        step();
        n++;
      end
      if (!seen_ack) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout_ack: no swap_ack within %0d clk", FRAME);
      end
    end
    swap_req = 1'b0;
    run(FRAME + FRAME / 2);
    check_eq("p2_toggles", 32'(toggles), 32'd1);
    check_eq("p2_sel", 32'(buffer_sel), 32'd1);

    // all-white framebuffer, swap_req held high: one swap per frame
    reset_n = 1'b0;
    @(negedge clk);
    fill(1);
    swap_req = 1'b1;
    release_reset();
    run(3 * FRAME);
    check_eq("p3_toggles", 32'(toggles), 32'd3);

    // random framebuffer and random swap_req, then reset mid-frame
    reset_n = 1'b0;
    @(negedge clk);
    fill(2);
    swap_req = 1'b0;
    release_reset();
    for (int i = 0; i < FRAME + FRAME / 3; i++) begin
      if ($urandom_range(0, 47) == 0) swap_req = ~swap_req;
      step();
    end
    run_until(5, 12, FRAME);
    #3 reset_n = 1'b0;
    #1 check_reset("mid");
    @(negedge clk);
    @(negedge clk);
    release_reset();
    run(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
